// File: rtl/qkd_mailbox_requester.sv
// qkd_mailbox_requester
// KCU116-side initiator of the shared-BRAM status-word handshake. Claims a
// slot in the status word on behalf of a local client, polls until the host
// agent answers READY in that slot, grants the client, then releases the
// mailbox and waits for the host's closing IDLE.
//
// Status word layout: [3:0] writer ID, slot n at [4n+7:4n+4] (n = 0..3),
// [63:20] owned by others and always written back unchanged from the shadow.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_slot    client request and slot index (accepted in IDLE)
//   req_ready             high only in IDLE
//   grant                 host answered READY; client owns the channel
//   client_done           client finished (sampled only while grant=1)
//   done                  one-cycle pulse when the transaction closes
//   busy                  high in every state except IDLE
//   timeout_err           sticky poll-timeout flag
//   bram_*                BRAM port A (single status word at STATUS_ADDR)
//   state                 current FSM state code
//
// Build option: define QKD_MAILBOX_TIMEOUT_EN to bound the polling loops by
// TIMEOUT_CYC cycles; without it polling is unbounded and timeout_err is 0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE     0 | waiting for a client request
// RD_FREE  1 | issue read of status word
// CHK_FREE 2 | wait for capture; all slots idle -> request, else re-poll
// WR_REQ   3 | write writer ID + REQUEST in the selected slot
// POLL_WAIT4 | pacing gap before the next READY poll
// POLL_RD  5 | issue read of status word
// POLL_CHK 6 | wait for capture; READY in selected slot -> grant
// GRANT    7 | client owns the channel until client_done
// WR_IDLE  8 | write writer ID + all slots IDLE
// ACK_WAIT 9 | paced polling until host writes its own all-IDLE word
// FINISH  10 | done pulse
module qkd_mailbox_requester #(
   parameter int                ADDR_W      = 10,
   parameter logic [ADDR_W-1:0] STATUS_ADDR = '0,
   parameter int                RD_LAT      = 2,
   parameter int                POLL_GAP    = 16,
   parameter logic [3:0]        IDLE_CODE   = 4'h0,
   parameter logic [3:0]        REQ_CODE    = 4'h1,
   parameter logic [3:0]        READY_CODE  = 4'h2,
   parameter logic [3:0]        WR_KCU      = 4'h1,
   parameter logic [3:0]        WR_HOST     = 4'h2,
   parameter int                TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [1:0]        req_slot,
   output logic              req_ready,
   output logic              grant,
   input  logic              client_done,
   output logic              done,
   output logic              busy,
   output logic              timeout_err,
   output logic              bram_en,
   output logic [7:0]        bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [63:0]       bram_din,
   input  logic [63:0]       bram_dout,
   output logic [3:0]        state
);

   localparam int LAT_W = $clog2(RD_LAT + 1);
   localparam int GAP_W = $clog2(POLL_GAP + 1);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_RD_FREE   = 4'd1,
      S_CHK_FREE  = 4'd2,
      S_WR_REQ    = 4'd3,
      S_POLL_WAIT = 4'd4,
      S_POLL_RD   = 4'd5,
      S_POLL_CHK  = 4'd6,
      S_GRANT     = 4'd7,
      S_WR_IDLE   = 4'd8,
      S_ACK_WAIT  = 4'd9,
      S_FINISH    = 4'd10
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         slot_q;
   logic [63:0]        shadow_q;
   logic [LAT_W-1:0]   lat_cnt_q;
   logic [GAP_W-1:0]   gap_cnt_q;
   logic               fresh_q;

   logic               rd_go, wr_go, gap_load, gap_dec, to_hit, to_fire;
   logic               rd_idle, gap_end, slots_idle, ack_ok;
   logic [5:0]         slot_lsb;
   logic [3:0]         slot_nib;
   logic [63:0]        wr_word;

   assign slot_lsb   = {2'b00, slot_q, 2'b00} + 6'd4;
   assign slot_nib   = shadow_q[slot_lsb +: 4];
   assign slots_idle = (shadow_q[7:4]   == IDLE_CODE) && (shadow_q[11:8]  == IDLE_CODE) &&
                       (shadow_q[15:12] == IDLE_CODE) && (shadow_q[19:16] == IDLE_CODE);
   assign ack_ok     = slots_idle && (shadow_q[3:0] == WR_HOST);
   assign rd_idle    = (lat_cnt_q == '0);
   assign gap_end    = (gap_cnt_q <= GAP_W'(1));

   // Every write is the shadow with the writer ID and slot field rebuilt.
   always_comb begin
      wr_word        = shadow_q;
      wr_word[3:0]   = WR_KCU;
      wr_word[19:4]  = {4{IDLE_CODE}};
      if (state_q == S_WR_REQ) wr_word[slot_lsb +: 4] = REQ_CODE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      grant     = 1'b0;
      done      = 1'b0;
      rd_go     = 1'b0;
      wr_go     = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
      to_fire   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = S_RD_FREE;
         end
         S_RD_FREE: begin
            rd_go    = 1'b1;
            gap_load = 1'b1;
            state_d  = S_CHK_FREE;
         end
         // Gap counts from the read issue so the read latency overlaps it.
         S_CHK_FREE: begin
            if (!gap_end) gap_dec = 1'b1;
            if (rd_idle) begin
               if (to_hit) begin
                  to_fire = 1'b1;
                  state_d = S_WR_IDLE;
               end else if (slots_idle) state_d = S_WR_REQ;
               else if (gap_end)        state_d = S_RD_FREE;
            end
         end
         S_WR_REQ: begin
            wr_go    = 1'b1;
            gap_load = 1'b1;
            state_d  = S_POLL_WAIT;
         end
         S_POLL_WAIT: begin
            if (to_hit && rd_idle) begin
               to_fire = 1'b1;
               state_d = S_WR_IDLE;
            end else if (gap_end) state_d = S_POLL_RD;
            else                  gap_dec = 1'b1;
         end
         S_POLL_RD: begin
            rd_go   = 1'b1;
            state_d = S_POLL_CHK;
         end
         S_POLL_CHK: begin
            if (rd_idle) begin
               if (to_hit) begin
                  to_fire = 1'b1;
                  state_d = S_WR_IDLE;
               end else if (slot_nib == READY_CODE) state_d = S_GRANT;
               else begin
                  gap_load = 1'b1;
                  state_d  = S_POLL_WAIT;
               end
            end
         end
         S_GRANT: begin
            grant = 1'b1;
            if (client_done) state_d = S_WR_IDLE;
         end
         S_WR_IDLE: begin
            wr_go    = 1'b1;
            gap_load = 1'b1;
            state_d  = S_ACK_WAIT;
         end
         // fresh_q keeps a stale pre-release shadow from closing the handshake.
         S_ACK_WAIT: begin
            if (!gap_end) gap_dec = 1'b1;
            if (rd_idle) begin
               if (fresh_q && ack_ok) state_d = S_FINISH;
               else if (to_hit) begin
                  to_fire = 1'b1;
                  state_d = S_WR_IDLE;
               end else if (gap_end) begin
                  rd_go    = 1'b1;
                  gap_load = 1'b1;
               end
            end
         end
         S_FINISH: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q    <= '0;
         shadow_q  <= '0;
         lat_cnt_q <= '0;
         gap_cnt_q <= '0;
         fresh_q   <= 1'b0;
      end else begin
         if (req_ready && req_valid) slot_q <= req_slot;
         if (rd_go)         lat_cnt_q <= LAT_W'(RD_LAT);
         else if (!rd_idle) lat_cnt_q <= lat_cnt_q - LAT_W'(1);
         if (lat_cnt_q == LAT_W'(1)) begin
            shadow_q <= bram_dout;
            fresh_q  <= 1'b1;
         end else if (wr_go) begin
            fresh_q  <= 1'b0;
         end
         if (gap_load)     gap_cnt_q <= GAP_W'(POLL_GAP);
         else if (gap_dec) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      end
   end

`ifdef QKD_MAILBOX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            to_err_q;
   logic            poll_st;

   assign poll_st = (state_q == S_CHK_FREE) || (state_q == S_POLL_WAIT) ||
                    (state_q == S_POLL_RD)  || (state_q == S_POLL_CHK)  ||
                    (state_q == S_ACK_WAIT);
   assign to_hit  = poll_st && (to_cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= TO_W'(TIMEOUT_CYC - 1);
         to_err_q <= 1'b0;
      end else begin
         if (!poll_st)             to_cnt_q <= TO_W'(TIMEOUT_CYC - 1);
         else if (to_cnt_q != '0)  to_cnt_q <= to_cnt_q - TO_W'(1);
         if (to_fire) to_err_q <= 1'b1;
      end
   end
   assign timeout_err = to_err_q;
`else
   logic [32:0] unused_timeout;
   assign to_hit         = 1'b0;
   assign timeout_err    = 1'b0;
   assign unused_timeout = {to_fire, 32'(TIMEOUT_CYC)};
`endif

   assign busy      = (state_q != S_IDLE);
   assign state     = state_q;
   assign bram_addr = STATUS_ADDR;
   assign bram_en   = rd_go | wr_go;
   assign bram_we   = {8{wr_go}};
   assign bram_din  = wr_go ? wr_word : 64'd0;

endmodule
